viterbi_traceback: RTL and testbench



---
 rtl/viterbi_traceback.sv | 182 ++++++++++++++++++
 tb/tb_viterbi_traceback.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_traceback.sv
// viterbi_traceback
// Survivor memory and traceback for the 4-state (K=3, rate-1/2) Viterbi
// decoder. It collects TB_DEPTH decision columns from the ACS array. It then
// traces back from the selected minimum-cost state and streams the decoded
// bits out in original order over a valid/ready handshake.
//
// Build option: define TB_ZERO_START_EN for terminated-trellis mode. In that
// mode traceback always starts from state 2'b00 and min_state is ignored.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous reset, active-low
//   dec_valid  in   a decision column is present
//   dec_bits   in   [3:0] survivor decision per state (bit s = state s)
//   min_state  in   [1:0] minimum-cost state, aligned with dec_bits
//   dec_ready  out  a column is accepted this cycle (FILL)
//   out_valid  out  out_bit is valid (OUTPUT)
//   out_bit    out  decoded information bit
//   out_ready  in   downstream accepts out_bit
//   busy       out  TRACE or OUTPUT in progress
//   overflow   out  sticky: a column arrived while dec_ready was low
//
// state  | meaning
// -------+-------------------------------------------------------------
// FILL   | accept columns into survivor memory; last column starts trace
// TRACE  | walk survivor memory from column TB_DEPTH-1 down to 0
// OUTPUT | stream obuf[0..TB_DEPTH-1] through the handshake

module viterbi_traceback #(
   parameter int TB_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dec_valid,
   input  logic [3:0] dec_bits,
   input  logic [1:0] min_state,
   output logic       dec_ready,
   output logic       out_valid,
   output logic       out_bit,
   input  logic       out_ready,
   output logic       busy,
   output logic       overflow
);

   localparam int IW = $clog2(TB_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(TB_DEPTH - 1);

   typedef enum logic [1:0] {
      S_FILL   = 2'd0,
      S_TRACE  = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next_state;

   logic [3:0]    r_mem  [TB_DEPTH];
   logic          r_obuf [TB_DEPTH];

   logic [IW-1:0] r_wr_idx;
   logic [IW-1:0] r_j;
   logic [IW-1:0] r_rd_idx;
   logic [1:0]    r_cur;
   logic          r_out_bit;
   logic          r_overflow;

   logic          w_dec_ready;
   logic          w_pred_bit;
   logic [1:0]    w_start_state;
   logic [IW-1:0] w_rd_nxt;

`ifdef TB_ZERO_START_EN
   assign w_start_state = 2'b00;
`else
   assign w_start_state = min_state;
`endif

   assign w_dec_ready = (r_state == S_FILL);
   assign w_pred_bit  = r_mem[r_j][r_cur];
   assign w_rd_nxt    = r_rd_idx + IW'(1);

   assign dec_ready = w_dec_ready;
   assign out_valid = (r_state == S_OUTPUT);
   assign busy      = (r_state == S_TRACE) || (r_state == S_OUTPUT);
   assign out_bit   = r_out_bit;
   assign overflow  = r_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FILL: begin
            if (dec_valid && (r_wr_idx == LAST_IDX)) begin
               w_next_state = S_TRACE;
            end
         end
         S_TRACE: begin
            if (r_j == '0) begin
               w_next_state = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (out_ready && (r_rd_idx == LAST_IDX)) begin
               w_next_state = S_FILL;
            end
         end
         default: w_next_state = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_idx   <= '0;
         r_j        <= '0;
         r_rd_idx   <= '0;
         r_cur      <= 2'b00;
         r_out_bit  <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (dec_valid && !w_dec_ready) begin
            r_overflow <= 1'b1;
         end
         case (r_state)
            S_FILL: begin
               if (dec_valid) begin
                  if (r_wr_idx == LAST_IDX) begin
                     r_wr_idx <= '0;
                     r_cur    <= w_start_state;
                     r_j      <= LAST_IDX;
                  end else begin
                     r_wr_idx <= r_wr_idx + IW'(1);
                  end
               end
            end
            S_TRACE: begin
               r_cur <= {r_cur[0], w_pred_bit};
               if (r_j == '0) begin
                  // obuf[0] is written on this same edge, so preload the
                  // output register straight from the trace state.
                  r_rd_idx  <= '0;
                  r_out_bit <= r_cur[1];
               end else begin
                  r_j <= r_j - IW'(1);
               end
            end
            S_OUTPUT: begin
               if (out_ready) begin
                  if (r_rd_idx == LAST_IDX) begin
                     r_rd_idx  <= '0;
                     r_out_bit <= 1'b0;
                  end else begin
                     r_rd_idx  <= w_rd_nxt;
                     r_out_bit <= r_obuf[w_rd_nxt];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Storage arrays carry no reset; their contents are don't-care until written.
   always_ff @(posedge clk) begin
      if ((r_state == S_FILL) && dec_valid) begin
         r_mem[r_wr_idx] <= dec_bits;
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_TRACE) begin
         r_obuf[r_j] <= r_cur[1];
      end
   end

endmodule

// File: tb/tb_viterbi_traceback.sv
module tb_viterbi_traceback;

   localparam int D = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       dec_valid;
   logic [3:0] dec_bits;
   logic [1:0] min_state;
   logic       dec_ready;
   logic       out_valid;
   logic       out_bit;
   logic       out_ready;
   logic       busy;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;

   logic [3:0] cols     [D];
   logic       exp_bits [D];
   logic [1:0] last_ms;

   always #5 clk = ~clk;

   viterbi_traceback #(.TB_DEPTH(D)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dec_valid (dec_valid),
      .dec_bits  (dec_bits),
      .min_state (min_state),
      .dec_ready (dec_ready),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .out_ready (out_ready),
      .busy      (busy),
      .overflow  (overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic fill_const(input logic [3:0] v, input logic [1:0] ms, input logic b);
      for (int j = 0; j < D; j++) begin
         cols[j]     = v;
         exp_bits[j] = b;
      end
      last_ms = ms;
   endtask

   // Builds columns from an encoder path u: state at column j is {u[j],u[j-1]},
   // its predecessor is {u[j-1],u[j-2]}, so the decision for that state is u[j-2].
   // Decisions for off-path states are random.
   task automatic fill_path(input logic [15:0] u);
      logic [1:0] s;
      logic       um1;
      logic       um2;
      logic [3:0] c;
      for (int j = 0; j < D; j++) begin
         um1 = (j >= 1) ? u[j-1] : 1'b0;
         um2 = (j >= 2) ? u[j-2] : 1'b0;
         s = {u[j], um1};
         c = 4'($urandom_range(0, 15));
         c[s] = um2;
         cols[j]     = c;
         exp_bits[j] = u[j];
      end
      last_ms = {u[D-1], u[D-2]};
   endtask

   task automatic send_frame(input bit ovf);
      int k;
      for (int j = 0; j < D; j++) begin
         @(negedge clk);
         dec_valid = 1'b1;
         dec_bits  = cols[j];
         min_state = (j == D-1) ? last_ms : 2'b00;
      end
      @(negedge clk);
      check("busy_trace", busy, 1);
      check("ready_trace", dec_ready, 0);
      dec_valid = ovf;
      dec_bits  = 4'hF;
      min_state = 2'b01;
      k = 1;
      while (!out_valid && k < 100) begin
         @(negedge clk);
         k++;
         if (k > 3) dec_valid = 1'b0;
      end
      dec_valid = 1'b0;
      check("latency", k, D + 1);
      if (ovf) check("overflow_set", overflow, 1);
   endtask

   task automatic recv_frame(input bit bp);
      int   n;
      int   cyc;
      logic rdy;
      logic stalled;
      logic held;
      logic [3:0] pat;
      pat     = 4'b1001;
      n       = 0;
      cyc     = 0;
      stalled = 1'b0;
      held    = 1'b0;
      check("busy_out", busy, 1);
      while (n < D && cyc < 400) begin
         rdy = bp ? pat[cyc % 4] : 1'b1;
         out_ready = rdy;
         if (out_valid) begin
            if (stalled) check("hold", out_bit, held);
            if (rdy) begin
               check($sformatf("bit%0d", n), out_bit, exp_bits[n]);
               n++;
               stalled = 1'b0;
            end else begin
               stalled = 1'b1;
               held    = out_bit;
            end
         end else begin
            check("valid_drop", out_valid, 1);
         end
         @(negedge clk);
         cyc++;
      end
      out_ready = 1'b0;
      check("accepts", n, D);
      check("ready_after", dec_ready, 1);
      check("valid_after", out_valid, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      dec_valid = 1'b0;
      dec_bits  = 4'h0;
      min_state = 2'b00;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_dec_ready", dec_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overflow", overflow, 0);
      check("rst_out_bit", out_bit, 0);
      rst_n = 1'b1;

      // reset asserted in the middle of TRACE
      fill_const(4'hF, 2'b11, 1'b1);
      for (int j = 0; j < D; j++) begin
         @(negedge clk);
         dec_valid = 1'b1;
         dec_bits  = cols[j];
         min_state = last_ms;
      end
      @(negedge clk);
      dec_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("mid_busy_pre", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_dec_ready", dec_ready, 1);
      check("mid_rst_out_bit", out_bit, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // fresh frame after reset: encoder path
      fill_path(16'h2D69);
      send_frame(1'b0);
      recv_frame(1'b0);

      // all-zero frame
      fill_const(4'h0, 2'b00, 1'b0);
      send_frame(1'b0);
      recv_frame(1'b0);

      // all-ones frame
      fill_const(4'hF, 2'b11, 1'b1);
      send_frame(1'b0);
      recv_frame(1'b0);

      // single late one
      fill_const(4'h0, 2'b10, 1'b0);
`ifndef TB_ZERO_START_EN
      exp_bits[D-1] = 1'b1;
`endif
      send_frame(1'b0);
      recv_frame(1'b0);

      // output backpressure with a different path
      fill_path(16'h1B37);
      send_frame(1'b0);
      recv_frame(1'b1);
      check("no_overflow", overflow, 0);

      // overflow during TRACE must not disturb the frame
      fill_path(16'h2D69);
      send_frame(1'b1);
      recv_frame(1'b0);
      check("overflow_sticky", overflow, 1);
      repeat (5) @(negedge clk);
      check("overflow_sticky2", overflow, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
